// File: rtl/pipe_scheduler.sv
// Pipe-column sequencer: paces columns with a tick divider, alternates gap/pipe runs, owns the pattern LFSR.
// Optional macro PIPE_SCHED_SPEEDUP_EN shortens the tick period as more pipes are spawned.
module pipe_scheduler #(
    parameter int         SPEED_DIV = 16,
    parameter int         GAP       = 4,
    parameter int         PIPE_W    = 2,
    parameter logic [7:0] LFSR_SEED = 8'hA5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        stop,
    output logic [7:0]  rng,
    input  logic [15:0] newPipe,
    output logic [15:0] col_data,
    output logic        col_valid,
    input  logic        col_ready,
    output logic [7:0]  spawn_count,
    output logic        busy
);
    localparam int DW = $clog2(SPEED_DIV);
    localparam int CW = $clog2((GAP > PIPE_W ? GAP : PIPE_W) + 1);

    typedef enum logic [1:0] {IDLE, EMPTY, PIPE} state_t;

    state_t         state_reg, state_next;
    logic [7:0]     lfsr_reg, lfsr_next;
    logic [15:0]    pipe_reg, pipe_next;
    logic [15:0]    data_reg, data_next;
    logic           valid_reg, valid_next;
    logic           pending_reg, pending_next;
    logic [7:0]     spawn_reg, spawn_next;
    logic [DW-1:0]  div_reg, div_next;
    logic [CW-1:0]  cnt_reg, cnt_next;
    logic           tick;
    logic           emit;

`ifdef PIPE_SCHED_SPEEDUP_EN
    localparam int STEP  = SPEED_DIV >> 4;
    localparam int FLOOR = SPEED_DIV >> 2;
    logic [DW:0] limit_reg, limit_next;
    int          reduce;
    int          speed_lim;

    always_comb begin
        reduce    = int'(spawn_reg >> 3) * STEP;
        speed_lim = (SPEED_DIV - reduce < FLOOR) ? FLOOR : SPEED_DIV - reduce;
    end

    assign tick = ({1'b0, div_reg} == limit_reg - 1'b1);
`else
    assign tick = (div_reg == DW'(SPEED_DIV - 1));
`endif

    always_comb begin
        state_next   = state_reg;
        lfsr_next    = lfsr_reg;
        pipe_next    = pipe_reg;
        data_next    = data_reg;
        valid_next   = valid_reg;
        pending_next = pending_reg;
        spawn_next   = spawn_reg;
        div_next     = div_reg;
        cnt_next     = cnt_reg;
        emit         = 1'b0;
`ifdef PIPE_SCHED_SPEEDUP_EN
        limit_next   = limit_reg;
`endif
        if (state_reg == IDLE) begin
            div_next = '0;
            if (start && !stop) begin
                state_next   = EMPTY;
                cnt_next     = CW'(GAP);
                spawn_next   = '0;
                lfsr_next    = LFSR_SEED;
                pending_next = 1'b0;
`ifdef PIPE_SCHED_SPEEDUP_EN
                limit_next   = (DW+1)'(SPEED_DIV);
`endif
            end
        end else if (stop) begin
            // Abort: the outstanding column is dropped, spawn_count and lfsr are kept for inspection
            state_next   = IDLE;
            valid_next   = 1'b0;
            pending_next = 1'b0;
            div_next     = '0;
        end else begin
            div_next = tick ? '0 : div_reg + 1'b1;
`ifdef PIPE_SCHED_SPEEDUP_EN
            if (tick)
                limit_next = (DW+1)'(speed_lim);
`endif
            if (valid_reg && col_ready)
                valid_next = 1'b0;
            // A tick that lands on an outstanding column is remembered once; extra ticks are lost
            if (tick && valid_reg)
                pending_next = 1'b1;
            emit = (tick || pending_reg) && !valid_reg;
            if (emit) begin
                pending_next = 1'b0;
                valid_next   = 1'b1;
                data_next    = (state_reg == PIPE) ? pipe_reg : 16'h0000;
                if (cnt_reg == CW'(1)) begin
                    if (state_reg == EMPTY) begin
                        state_next = PIPE;
                        pipe_next  = newPipe;
                        lfsr_next  = {lfsr_reg[6:0], lfsr_reg[7] ^ lfsr_reg[5] ^ lfsr_reg[4] ^ lfsr_reg[3]};
                        if (spawn_reg != 8'hFF)
                            spawn_next = spawn_reg + 8'd1;
                        cnt_next   = CW'(PIPE_W);
                    end else begin
                        state_next = EMPTY;
                        cnt_next   = CW'(GAP);
                    end
                end else begin
                    cnt_next = cnt_reg - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg   <= IDLE;
            lfsr_reg    <= LFSR_SEED;
            pipe_reg    <= '0;
            data_reg    <= '0;
            valid_reg   <= 1'b0;
            pending_reg <= 1'b0;
            spawn_reg   <= '0;
            div_reg     <= '0;
            cnt_reg     <= '0;
`ifdef PIPE_SCHED_SPEEDUP_EN
            limit_reg   <= (DW+1)'(SPEED_DIV);
`endif
        end else begin
            state_reg   <= state_next;
            lfsr_reg    <= lfsr_next;
            pipe_reg    <= pipe_next;
            data_reg    <= data_next;
            valid_reg   <= valid_next;
            pending_reg <= pending_next;
            spawn_reg   <= spawn_next;
            div_reg     <= div_next;
            cnt_reg     <= cnt_next;
`ifdef PIPE_SCHED_SPEEDUP_EN
            limit_reg   <= limit_next;
`endif
        end
    end

    assign rng         = lfsr_reg;
    assign col_data    = data_reg;
    assign col_valid   = valid_reg;
    assign spawn_count = spawn_reg;
    assign busy        = (state_reg != IDLE);

endmodule

// File: tb/tb_pipe_scheduler.sv
// Self-checking bench for pipe_scheduler: vector table for the first run, hand sequences for
// backpressure, stop/restart, a 20-pipe LFSR sweep, tick period on a slow instance and async reset.
module tb_pipe_scheduler;
    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, start, stop, col_ready;
    logic [7:0]  rng, spawn_count;
    logic [15:0] new_pipe, col_data;
    logic        col_valid, busy;

    logic        start_f;
    logic [7:0]  rng_f, spawn_f;
    logic [15:0] new_pipe_f, data_f;
    logic        valid_f, busy_f;

    int checks = 0;
    int errors = 0;
    int tcyc;

`ifdef PIPE_SCHED_SPEEDUP_EN
    localparam int EXP_PERIOD = 60;
`else
    localparam int EXP_PERIOD = 64;
`endif

    function automatic logic [15:0] pat(input logic [7:0] r);
        return {r ^ 8'h3C, ~r};
    endfunction

    // Reference LFSR: taps x^8,x^6,x^5,x^4 -> bits 7,5,4,3 (mask B8)
    function automatic logic [7:0] lfsr_nxt(input logic [7:0] r);
        return (r << 1) | {7'd0, ^(r & 8'hB8)};
    endfunction

    assign new_pipe   = pat(rng);
    assign new_pipe_f = pat(rng_f);

    pipe_scheduler #(.SPEED_DIV(4), .GAP(2), .PIPE_W(2), .LFSR_SEED(8'hA5)) u_dut (
        .clk(clk), .reset(reset), .start(start), .stop(stop), .rng(rng), .newPipe(new_pipe),
        .col_data(col_data), .col_valid(col_valid), .col_ready(col_ready),
        .spawn_count(spawn_count), .busy(busy)
    );

    pipe_scheduler #(.SPEED_DIV(64), .GAP(1), .PIPE_W(1), .LFSR_SEED(8'hA5)) u_fast (
        .clk(clk), .reset(reset), .start(start_f), .stop(1'b0), .rng(rng_f), .newPipe(new_pipe_f),
        .col_data(data_f), .col_valid(valid_f), .col_ready(1'b1),
        .spawn_count(spawn_f), .busy(busy_f)
    );

    typedef struct {
        int          cyc;
        logic        valid;
        logic [15:0] data;
        logic [7:0]  spawn;
        logic [7:0]  rng;
    } vec_t;
    vec_t vecs [9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            $display("ok   %s = %h", name, act);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic advance_to(input int target);
        while (tcyc < target) begin
            step();
            tcyc++;
        end
    endtask

    task automatic wait_valid(input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 16 && !seen; i++) begin
            step();
            if (col_valid) seen = 1'b1;
        end
        check({name, " valid_seen"}, {31'd0, seen}, 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  s1, s2, r;
        logic [15:0] pa;
        int          rises;
        int          n;
        int          t1;
        bit          found;

        s1 = lfsr_nxt(8'hA5);
        s2 = lfsr_nxt(s1);
        pa = pat(8'hA5);
        vecs[0] = '{3,  1'b0, 16'h0000, 8'd0, 8'hA5};
        vecs[1] = '{4,  1'b1, 16'h0000, 8'd0, 8'hA5};
        vecs[2] = '{5,  1'b0, 16'h0000, 8'd0, 8'hA5};
        vecs[3] = '{8,  1'b1, 16'h0000, 8'd1, s1};
        vecs[4] = '{9,  1'b0, 16'h0000, 8'd1, s1};
        vecs[5] = '{12, 1'b1, pa,       8'd1, s1};
        vecs[6] = '{13, 1'b0, pa,       8'd1, s1};
        vecs[7] = '{16, 1'b1, pa,       8'd1, s1};
        vecs[8] = '{17, 1'b0, pa,       8'd1, s1};

        reset = 1'b1; start = 1'b0; stop = 1'b0; col_ready = 1'b1; start_f = 1'b0;
        repeat (3) step();
        check("rst col_valid", {31'd0, col_valid}, 32'd0);
        check("rst busy", {31'd0, busy}, 32'd0);
        check("rst rng", {24'd0, rng}, 32'hA5);
        check("rst spawn", {24'd0, spawn_count}, 32'd0);
        check("rst col_data", {16'd0, col_data}, 32'd0);
        reset = 1'b0;

        rises = 0;
        for (int i = 0; i < 100; i++) begin
            step();
            if (col_valid) rises++;
        end
        check("idle valid_rises", rises, 32'd0);
        check("idle busy", {31'd0, busy}, 32'd0);

        start = 1'b1; stop = 1'b1;
        step();
        start = 1'b0; stop = 1'b0;
        check("stop_beats_start busy", {31'd0, busy}, 32'd0);

        // Run 1: vector table
        start = 1'b1;
        step();
        start = 1'b0;
        tcyc = 0;
        check("run1 busy", {31'd0, busy}, 32'd1);
        for (int i = 0; i < 9; i++) begin
            advance_to(vecs[i].cyc);
            check($sformatf("vec%0d c%0d valid", i, vecs[i].cyc), {31'd0, col_valid}, {31'd0, vecs[i].valid});
            check($sformatf("vec%0d c%0d data", i, vecs[i].cyc), {16'd0, col_data}, {16'd0, vecs[i].data});
            check($sformatf("vec%0d c%0d spawn", i, vecs[i].cyc), {24'd0, spawn_count}, {24'd0, vecs[i].spawn});
            check($sformatf("vec%0d c%0d rng", i, vecs[i].cyc), {24'd0, rng}, {24'd0, vecs[i].rng});
        end

        // stop while a column is outstanding
        col_ready = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            step();
            if (col_valid) found = 1'b1;
        end
        check("stop pre valid", {31'd0, found}, 32'd1);
        stop = 1'b1;
        step();
        stop = 1'b0;
        check("stop col_valid", {31'd0, col_valid}, 32'd0);
        check("stop busy", {31'd0, busy}, 32'd0);
        check("stop spawn kept", {24'd0, spawn_count}, 32'd1);
        check("stop rng kept", {24'd0, rng}, {24'd0, s1});
        start = 1'b1;
        step();
        start = 1'b0;
        tcyc = 0;
        check("restart rng", {24'd0, rng}, 32'hA5);
        check("restart spawn", {24'd0, spawn_count}, 32'd0);
        check("restart busy", {31'd0, busy}, 32'd1);

        // Backpressure: ready low for cycles 4..13
        advance_to(4);
        check("bp c4 valid", {31'd0, col_valid}, 32'd1);
        for (int c = 5; c <= 13; c++) begin
            advance_to(c);
            check($sformatf("bp c%0d valid_held", c), {31'd0, col_valid}, 32'd1);
            check($sformatf("bp c%0d data_held", c), {16'd0, col_data}, 32'd0);
        end
        col_ready = 1'b1;
        advance_to(14);
        check("bp c14 valid", {31'd0, col_valid}, 32'd0);
        advance_to(15);
        check("bp c15 valid", {31'd0, col_valid}, 32'd1);
        check("bp c15 data", {16'd0, col_data}, 32'd0);
        check("bp c15 spawn", {24'd0, spawn_count}, 32'd1);
        advance_to(16);
        check("bp c16 valid", {31'd0, col_valid}, 32'd0);
        advance_to(17);
        check("bp c17 valid", {31'd0, col_valid}, 32'd1);
        check("bp c17 data", {16'd0, col_data}, {16'd0, pa});
        advance_to(19);
        check("bp c19 valid", {31'd0, col_valid}, 32'd0);
        advance_to(20);
        check("bp c20 valid", {31'd0, col_valid}, 32'd1);
        check("bp c20 data", {16'd0, col_data}, {16'd0, pa});
        advance_to(24);
        check("bp c24 data", {16'd0, col_data}, 32'd0);
        advance_to(28);
        check("bp c28 valid", {31'd0, col_valid}, 32'd1);
        check("bp c28 spawn", {24'd0, spawn_count}, 32'd2);
        check("bp c28 rng", {24'd0, rng}, {24'd0, s2});

        // 20-pipe sweep from a fresh start
        stop = 1'b1;
        step();
        stop = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        r = 8'hA5;
        for (int k = 0; k < 20; k++) begin
            for (int j = 0; j < 2; j++) begin
                wait_valid($sformatf("p%0d gap%0d", k, j));
                check($sformatf("p%0d gap%0d data", k, j), {16'd0, col_data}, 32'd0);
            end
            check($sformatf("p%0d rng", k), {24'd0, rng}, {24'd0, lfsr_nxt(r)});
            check($sformatf("p%0d spawn", k), {24'd0, spawn_count}, k + 1);
            for (int j = 0; j < 2; j++) begin
                wait_valid($sformatf("p%0d col%0d", k, j));
                check($sformatf("p%0d col%0d data", k, j), {16'd0, col_data}, {16'd0, pat(r)});
            end
            r = lfsr_nxt(r);
        end
        check("sweep spawn_final", {24'd0, spawn_count}, 32'd20);

        // Tick period on the SPEED_DIV=64 instance after 9 pipes
        start_f = 1'b1;
        step();
        start_f = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 3000 && !found; i++) begin
            step();
            if (spawn_f >= 8'd9) found = 1'b1;
        end
        check("fast spawn9 reached", {31'd0, found}, 32'd1);
        n = 0;
        t1 = 0;
        rises = 0;
        for (int i = 0; i < 300 && rises < 2; i++) begin
            step();
            n++;
            if (valid_f) begin
                rises++;
                if (rises == 1) t1 = n;
            end
        end
        check("fast period", n - t1, EXP_PERIOD);

        // Asynchronous reset mid-run, sampled before the next clock edge
        reset = 1'b1;
        #2;
        check("async_rst busy", {31'd0, busy}, 32'd0);
        check("async_rst spawn", {24'd0, spawn_count}, 32'd0);
        check("async_rst rng", {24'd0, rng}, 32'hA5);
        check("async_rst col_valid", {31'd0, col_valid}, 32'd0);
        check("async_rst fast busy", {31'd0, busy_f}, 32'd0);
        reset = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
